// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
// Instruction fetch stage in front of the decoder. Walks the program counter
// through an 8-bit program ROM, captures an opcode byte and, for two-byte
// opcodes, the following operand byte. The assembled instruction is then
// offered to the decoder over a valid/ready handshake. Fetch stops after an
// accepted HLT until resume or a pc_load redirect.
//
// Ports
//   clk        in   1  rising-edge clock
//   rst        in   1  asynchronous active-low reset
//   rom_data   in   8  ROM read data (combinational from rom_addr)
//   rom_addr   out  8  ROM byte address, always the PC
//   rom_read   out  1  ROM read strobe
//   rom_ena    out  1  ROM enable (identical to rom_read)
//   ins_valid  out  1  instruction offered to the decoder
//   ins_ready  in   1  decoder accepts the instruction
//   opcode     out  3  opcode byte [7:5]
//   reg_sel    out  5  opcode byte [4:0]
//   operand    out  8  operand byte, 8'h00 for one-byte instructions
//   two_byte   out  1  instruction carried an operand byte
//   ins_pc     out  8  address of the opcode byte
//   halted     out  1  fetch stopped on HLT
//   resume     in   1  single-cycle pulse that leaves HALT
//   pc_load    in   1  redirect strobe, highest priority
//   pc_target  in   8  redirect address
// ---------------------------------------------------------------------------
module inst_fetch #(
    parameter logic [7:0] RESET_PC      = 8'h00,
    parameter logic [7:0] TWO_BYTE_MASK = 8'b0000_1110,
    parameter logic [2:0] HLT_OPC       = 3'b111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rom_data,
    output logic [7:0] rom_addr,
    output logic       rom_read,
    output logic       rom_ena,
    output logic       ins_valid,
    input  logic       ins_ready,
    output logic [2:0] opcode,
    output logic [4:0] reg_sel,
    output logic [7:0] operand,
    output logic       two_byte,
    output logic [7:0] ins_pc,
    output logic       halted,
    input  logic       resume,
    input  logic       pc_load,
    input  logic [7:0] pc_target
);

    typedef enum logic [1:0] {
        S_FETCH_OP  = 2'd0,
        S_FETCH_ARG = 2'd1,
        S_ISSUE     = 2'd2,
        S_HALT      = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_pc;
    logic [7:0] r_ir;
    logic [7:0] r_operand;
    logic       r_two_byte;
    logic [7:0] r_ins_pc;
    logic       w_rom_rd;
    logic       w_valid;
    logic       w_halted;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH_OP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        w_state_nxt = r_state;
        w_rom_rd    = 1'b0;
        w_valid     = 1'b0;
        w_halted    = 1'b0;
        case (r_state)
            S_FETCH_OP: begin
                w_rom_rd = 1'b1;
                // The opcode byte is on rom_data right now, so the mask
                // decides whether an operand fetch follows.
                if (TWO_BYTE_MASK[rom_data[7:5]]) begin
                    w_state_nxt = S_FETCH_ARG;
                end else begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_FETCH_ARG: begin
                w_rom_rd    = 1'b1;
                w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                w_valid = 1'b1;
                if (ins_ready) begin
                    if (r_ir[7:5] == HLT_OPC) begin
                        w_state_nxt = S_HALT;
                    end else begin
                        w_state_nxt = S_FETCH_OP;
                    end
                end
            end
            S_HALT: begin
                w_halted = 1'b1;
                if (resume) begin
                    w_state_nxt = S_FETCH_OP;
                end
            end
            default: w_state_nxt = S_FETCH_OP;
        endcase
        // A redirect overrides every state and any resume; a transfer on
        // the same edge has already happened on the decoder side.
        if (pc_load) begin
            w_state_nxt = S_FETCH_OP;
        end
    end

    // PC and instruction registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc       <= RESET_PC;
            r_ir       <= 8'h00;
            r_operand  <= 8'h00;
            r_two_byte <= 1'b0;
            r_ins_pc   <= 8'h00;
        end else if (pc_load) begin
            // Partially fetched or unaccepted instruction is dropped.
            r_pc       <= pc_target;
            r_operand  <= 8'h00;
            r_two_byte <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH_OP: begin
                    r_ir       <= rom_data;
                    r_ins_pc   <= r_pc;
                    r_pc       <= r_pc + 8'd1;
                    r_two_byte <= TWO_BYTE_MASK[rom_data[7:5]];
                end
                S_FETCH_ARG: begin
                    r_operand <= rom_data;
                    r_pc      <= r_pc + 8'd1;
                end
                default: begin
                    // Every entry into FETCH_OP starts from a clean operand.
                    if (w_state_nxt == S_FETCH_OP) begin
                        r_operand  <= 8'h00;
                        r_two_byte <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign rom_addr  = r_pc;
    assign rom_read  = w_rom_rd;
    assign rom_ena   = w_rom_rd;
    assign ins_valid = w_valid;
    assign halted    = w_halted;
    assign opcode    = r_ir[7:5];
    assign reg_sel   = r_ir[4:0];
    assign operand   = r_operand;
    assign two_byte  = r_two_byte;
    assign ins_pc    = r_ins_pc;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    logic       clk;
    logic       rst;
    logic [7:0] rom_data;
    logic [7:0] rom_addr;
    logic       rom_read;
    logic       rom_ena;
    logic       ins_valid;
    logic       ins_ready;
    logic [2:0] opcode;
    logic [4:0] reg_sel;
    logic [7:0] operand;
    logic       two_byte;
    logic [7:0] ins_pc;
    logic       halted;
    logic       resume;
    logic       pc_load;
    logic [7:0] pc_target;

    logic [7:0] mem [0:255];

    int n_tests = 0;
    int n_fail  = 0;

    inst_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .rom_data  (rom_data),
        .rom_addr  (rom_addr),
        .rom_read  (rom_read),
        .rom_ena   (rom_ena),
        .ins_valid (ins_valid),
        .ins_ready (ins_ready),
        .opcode    (opcode),
        .reg_sel   (reg_sel),
        .operand   (operand),
        .two_byte  (two_byte),
        .ins_pc    (ins_pc),
        .halted    (halted),
        .resume    (resume),
        .pc_load   (pc_load),
        .pc_target (pc_target)
    );

    assign rom_data = (rom_read && rom_ena) ? mem[rom_addr] : 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fetch(input string tag, input logic [7:0] a);
        int n;
        n = 0;
        while (!(rom_read && rom_addr == a) && n < 200) begin
            step();
            n++;
        end
        check(tag, {31'd0, rom_read && rom_addr == a}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[1]   = 8'h21;
        mem[2]   = 8'h41;
        mem[7]   = 8'h81;
        mem[19]  = 8'hE0;
        mem[20]  = 8'h61;
        mem[21]  = 8'h33;
        mem[255] = 8'h61;

        rst       = 1'b0;
        ins_ready = 1'b1;
        resume    = 1'b0;
        pc_load   = 1'b0;
        pc_target = 8'h00;

        // Reset values
        #12;
        check("rst_valid",   ins_valid, 0);
        check("rst_halted",  halted,    0);
        check("rst_opcode",  opcode,    0);
        check("rst_reg_sel", reg_sel,   0);
        check("rst_operand", operand,   0);
        check("rst_two",     two_byte,  0);
        check("rst_ins_pc",  ins_pc,    0);
        check("rst_addr",    rom_addr,  0);

        @(posedge clk);
        #1 rst = 1'b1;

        // NOP at 0
        check("nop_addr",  rom_addr,  8'h00);
        check("nop_read",  rom_read,  1);
        check("nop_ena",   rom_ena,   1);
        check("nop_v0",    ins_valid, 0);
        step();
        check("nop_valid", ins_valid, 1);
        check("nop_opc",   opcode,    0);
        check("nop_reg",   reg_sel,   0);
        check("nop_opnd",  operand,   0);
        check("nop_two",   two_byte,  0);
        check("nop_inspc", ins_pc,    0);
        check("nop_rd0",   rom_read,  0);

        // LDO s1,65 at 1..2
        step();
        check("ldo_addr1", rom_addr,  8'h01);
        check("ldo_read1", rom_read,  1);
        step();
        check("ldo_addr2", rom_addr,  8'h02);
        check("ldo_read2", rom_read,  1);
        check("ldo_v0",    ins_valid, 0);
        step();
        check("ldo_valid", ins_valid, 1);
        check("ldo_opc",   opcode,    1);
        check("ldo_reg",   reg_sel,   1);
        check("ldo_opnd",  operand,   8'h41);
        check("ldo_two",   two_byte,  1);
        check("ldo_inspc", ins_pc,    8'h01);
        step();
        check("ldo_next",  rom_addr,  8'h03);
        check("ldo_nrd",   rom_read,  1);

        // Backpressure on PRE s1 at 7
        wait_fetch("to_7", 8'h07);
        ins_ready = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", ins_valid, 1);
            check("bp_opc",   opcode,    4);
            check("bp_reg",   reg_sel,   1);
            check("bp_opnd",  operand,   0);
            check("bp_inspc", ins_pc,    8'h07);
            check("bp_read",  rom_read,  0);
            check("bp_pc",    rom_addr,  8'h08);
            step();
        end
        ins_ready = 1'b1;
        step();
        check("bp_after_v",  ins_valid, 0);
        check("bp_after_a",  rom_addr,  8'h08);
        check("bp_after_rd", rom_read,  1);

        // HLT at 19
        wait_fetch("to_19", 8'h13);
        step();
        check("hlt_valid", ins_valid, 1);
        check("hlt_opc",   opcode,    7);
        step();
        for (int i = 0; i < 10; i++) begin
            check("halt_h",  halted,    1);
            check("halt_v",  ins_valid, 0);
            check("halt_rd", rom_read,  0);
            check("halt_a",  rom_addr,  8'h14);
            step();
        end
        resume = 1'b1;
        step();
        resume = 1'b0;
        check("res_h",  halted,   0);
        check("res_a",  rom_addr, 8'h14);
        check("res_rd", rom_read, 1);

        // Redirect during FETCH_ARG of STO at 20
        mem[0] = 8'h02;
        step();
        check("sto_arg_a", rom_addr, 8'h15);
        check("sto_arg_r", rom_read, 1);
        pc_load   = 1'b1;
        pc_target = 8'hFF;
        step();
        pc_load = 1'b0;
        check("rd_valid", ins_valid, 0);
        check("rd_addr",  rom_addr,  8'hFF);
        check("rd_read",  rom_read,  1);
        step();
        check("wrap_addr", rom_addr, 8'h00);
        check("wrap_read", rom_read, 1);
        step();
        check("rd_iv",    ins_valid, 1);
        check("rd_inspc", ins_pc,    8'hFF);
        check("rd_opc",   opcode,    3);
        check("rd_reg",   reg_sel,   1);
        check("rd_opnd",  operand,   8'h02);
        check("rd_two",   two_byte,  1);
        step();
        check("rd_next",  rom_addr,  8'h01);

        // Reset during ISSUE with ins_ready low
        ins_ready = 1'b0;
        step();
        step();
        check("pre_rst_v", ins_valid, 1);
        #2 rst = 1'b0;
        #1;
        check("ar_valid",  ins_valid, 0);
        check("ar_opc",    opcode,    0);
        check("ar_reg",    reg_sel,   0);
        check("ar_opnd",   operand,   0);
        check("ar_two",    two_byte,  0);
        check("ar_inspc",  ins_pc,    0);
        check("ar_halted", halted,    0);
        check("ar_addr",   rom_addr,  8'h00);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        ins_ready = 1'b1;
        check("post_addr", rom_addr, 8'h00);
        check("post_read", rom_read, 1);
        step();
        check("post_v",    ins_valid, 1);
        check("post_reg",  reg_sel,   2);
        check("post_pc",   ins_pc,    0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction fetch stage that sits directly upstream of the decoder and drives the 8-bit program ROM's address, read and enable inputs. It walks the program counter and captures one opcode byte. For two-byte instructions it also captures the following operand byte. It then presents the assembled instruction to the decoder over a valid/ready handshake. It stops fetching after an accepted HLT until resumed or redirected.

Parameters:
RESET_PC, 8'h00, PC value loaded on reset.
TWO_BYTE_MASK, 8'b0000_1110, bit n set means opcode n takes an operand byte. Default covers LDO=1, LDA=2, STO=3.
HLT_OPC, 3'b111, opcode that halts fetch once accepted.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
rom_data  in  8  ROM read data. Combinational from rom_addr while rom_read and rom_ena are both high.
rom_addr  out  8  ROM byte address (the PC).
rom_read  out  1  ROM read strobe.
rom_ena  out  1  ROM enable.
ins_valid  out  1  instruction presented to the decoder.
ins_ready  in  1  decoder accepts the instruction.
opcode  out  3  bits [7:5] of the opcode byte.
reg_sel  out  5  bits [4:0] of the opcode byte.
operand  out  8  operand byte. 8'h00 for one-byte instructions.
two_byte  out  1  instruction had an operand byte.
ins_pc  out  8  address of the opcode byte.
halted  out  1  fetch stopped on HLT.
resume  in  1  single-cycle pulse; leaves HALT.
pc_load  in  1  redirect strobe.
pc_target  in  8  redirect address.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, state=FETCH_OP.
  - ins_valid=0, halted=0.
  - opcode, reg_sel, operand, ins_pc=0; two_byte=0.
- States and transitions:
  - FETCH_OP: rom_addr=pc, rom_read=rom_ena=1. On the clock edge: ir<=rom_data, ins_pc<=pc, pc<=pc+1. Next state is FETCH_ARG if TWO_BYTE_MASK[rom_data[7:5]], else ISSUE.
  - FETCH_ARG: rom_addr=pc, rom_read=rom_ena=1. On the clock edge: operand<=rom_data, pc<=pc+1, next state ISSUE.
  - ISSUE: ins_valid=1, rom_read=rom_ena=0. When ins_ready=1: if opcode==HLT_OPC go to HALT, else go to FETCH_OP.
  - HALT: ins_valid=0, halted=1, rom_read=rom_ena=0. Stays in HALT until resume=1, then goes to FETCH_OP with pc unchanged (pointing past the HLT).
- rom_read and rom_ena are identical and high only in FETCH_OP and FETCH_ARG.
- rom_addr=pc in every state.
- Entering FETCH_OP from any path clears operand to 8'h00 and two_byte to 0.
- two_byte is set on the FETCH_OP edge when the mask bit is set.
- Handshake:
  - A transfer occurs on a clock edge where ins_valid && ins_ready.
  - While ins_valid=1 and ins_ready=0, all instruction outputs are held stable.
  - ins_valid is never dropped without a transfer, except by pc_load or reset.
- Latency and throughput:
  - ins_valid rises 1 edge after entering FETCH_OP for a one-byte instruction, 2 edges for a two-byte instruction.
  - With ins_ready tied high: a one-byte instruction issues every 2 cycles, a two-byte instruction every 3 cycles.
- Redirect:
  - pc_load=1 has priority over every state and over resume.
  - At the edge: pc<=pc_target, state<=FETCH_OP, ins_valid<=0, halted<=0.
  - Any partially fetched or unaccepted instruction is discarded.
  - pc_load coincident with a transfer: the transfer completes and the redirect still applies.
- Wrap: pc increments modulo 256 (8'hFF+1=8'h00). This includes an operand fetch at 8'h00 after an opcode at 8'hFF.
- resume outside HALT is ignored.
- Reset asserted mid-fetch or mid-handshake returns immediately to the reset state. No instruction is issued from the aborted fetch.

Test Plan:
- ROM mem[0]=8'h00 (NOP), ins_ready=1, release reset → rom_addr=0 with read/ena high on cycle 1. Cycle 2: ins_valid=1, opcode=0, reg_sel=0, operand=0, two_byte=0, ins_pc=0.
- mem[1]=8'h21, mem[2]=8'h41 (LDO s1,65) → two consecutive ROM reads at 1 then 2. Then ins_valid with opcode=1, reg_sel=1, operand=8'h41, two_byte=1, ins_pc=1; next fetch at addr 3.
- Hold ins_ready=0 for 5 cycles while mem[7]=8'h81 (PRE s1) is presented → outputs stable, rom_read=0, no pc change. Raise ins_ready → single transfer, next fetch at 8.
- mem[19]=8'hE0 (HLT) accepted → halted=1, ins_valid=0, rom_read=0 for 10 cycles. Pulse resume → fetch at addr 20.
- pc_load=1, pc_target=8'hFF during FETCH_ARG of a STO; mem[255]=8'h61 (STO s1), mem[0]=8'h02 → the STO is dropped. The next issue has ins_pc=8'hFF, operand=8'h02, two_byte=1; the following fetch is at addr 1.
- Assert rst low during ISSUE with ins_ready=0 → outputs go to reset values immediately. After release, the first fetch is at RESET_PC.
